// File: rtl/simon_pkg.sv
// Shared Simon types: colour index, player state encoding, colour-to-LED decode
// and default playback timing.
package simon_pkg;

  typedef logic [1:0] color_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ON    = 2'd2,
    GAP   = 2'd3
  } player_state_t;

  localparam int DEF_N          = 10;
  localparam int DEF_ON_CYCLES  = 4;
  localparam int DEF_OFF_CYCLES = 2;

  function automatic logic [3:0] color_to_led(input color_t c);
    logic [3:0] led_v;
    case (c)
      2'd0:    led_v = 4'b0001;
      2'd1:    led_v = 4'b0010;
      2'd2:    led_v = 4'b0100;
      2'd3:    led_v = 4'b1000;
      default: led_v = 4'b0000;
    endcase
    return led_v;
  endfunction

endpackage

// File: rtl/sequence_player_timer.sv
// play_timer: loadable down-counter shared by the ON and GAP phases of
// sequence_player; expired is high while the count sits at zero.
module play_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired
);

  logic [W-1:0] count_r;

  // Load has priority; otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != '0) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == '0);

endmodule

// File: rtl/sequence_player.sv
// sequence_player: plays the first `length` colours of sequence_rom on the LEDs.
// Optional SEQUENCE_PLAYER_ABORT_EN adds an `abort` input that cancels playback.
module sequence_player
  import simon_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int ON_CYCLES  = DEF_ON_CYCLES,
  parameter int OFF_CYCLES = DEF_OFF_CYCLES,
  localparam int AW        = (N > 1) ? $clog2(N) : 1,
  localparam int LW        = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
`ifdef SEQUENCE_PLAYER_ABORT_EN
  input  logic          abort,
`endif
  input  logic          start,
  input  logic [LW-1:0] length,
  input  color_t        rd_data,
  output logic [AW-1:0] rd_addr,
  output logic [3:0]    led,
  output logic          busy,
  output logic          done
);

  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  player_state_t state_r;
  logic [LW-1:0] len_r;
  logic [AW-1:0] idx_r;
  logic [AW-1:0] rd_addr_r;
  logic [3:0]    led_r;
  logic          busy_r;
  logic          done_r;

  logic          abort_s;
  logic          last_s;
  logic          timer_expired_s;
  logic          timer_load_s;
  logic [TW-1:0] timer_value_s;
  logic [LW-1:0] len_clamped_s;

`ifdef SEQUENCE_PLAYER_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign last_s        = (LW'(idx_r) == (len_r - LW'(1)));
  assign len_clamped_s = (length > LW'(N)) ? LW'(N) : length;

  // Timer reload: ON time on FETCH exit, gap time when a non-final colour ends.
  always_comb begin
    timer_load_s  = 1'b0;
    timer_value_s = '0;
    case (state_r)
      FETCH: begin
        timer_load_s  = 1'b1;
        timer_value_s = TW'(ON_CYCLES - 1);
      end
      ON: begin
        if (timer_expired_s && !last_s) begin
          timer_load_s  = 1'b1;
          timer_value_s = TW'(OFF_CYCLES - 1);
        end else begin
          timer_load_s  = 1'b0;
          timer_value_s = '0;
        end
      end
      default: begin
        timer_load_s  = 1'b0;
        timer_value_s = '0;
      end
    endcase
  end

  play_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load_s),
    .load_value (timer_value_s),
    .expired    (timer_expired_s)
  );

  // Playback FSM with registered LED, address, busy and done outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      len_r     <= '0;
      idx_r     <= '0;
      rd_addr_r <= '0;
      led_r     <= 4'b0000;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (length == '0) begin
              done_r <= 1'b1;
            end else begin
              len_r     <= len_clamped_s;
              idx_r     <= '0;
              rd_addr_r <= '0;
              busy_r    <= 1'b1;
              state_r   <= FETCH;
            end
          end
        end
        FETCH: begin
          led_r   <= color_to_led(rd_data);
          state_r <= ON;
        end
        ON: begin
          if (timer_expired_s) begin
            led_r <= 4'b0000;
            if (last_s) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= IDLE;
            end else begin
              state_r <= GAP;
            end
          end
        end
        GAP: begin
          if (timer_expired_s) begin
            idx_r     <= idx_r + AW'(1);
            rd_addr_r <= idx_r + AW'(1);
            state_r   <= FETCH;
          end
        end
        default: begin
          led_r   <= 4'b0000;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
      // Abort overrides everything, including the final-colour done pulse.
      if (abort_s && (state_r != IDLE)) begin
        led_r   <= 4'b0000;
        busy_r  <= 1'b0;
        done_r  <= 1'b0;
        state_r <= IDLE;
      end
    end
  end

  assign rd_addr = rd_addr_r;
  assign led     = led_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_sequence_player.sv
// Scoreboard bench for sequence_player: stimulus pushes expected LED/done events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_sequence_player;

  localparam int N   = 10;
  localparam int ON  = 4;
  localparam int OFF = 2;

  typedef struct {
    int led;
    int cyc;
    int addr;
  } ev_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] length;
  logic [1:0] rd_data;
  logic [3:0] rd_addr;
  logic [3:0] led;
  logic       busy;
  logic       done;
`ifdef SEQUENCE_PLAYER_ABORT_EN
  logic       abort;
`endif

  logic [1:0] rom [16];
  int         cyc;
  int         t0;
  int         total;
  int         bad;
  ev_t        led_q[$];
  int         done_q[$];

  sequence_player #(.N(N), .ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
    .clk     (clk),
    .reset   (reset),
`ifdef SEQUENCE_PLAYER_ABORT_EN
    .abort   (abort),
`endif
    .start   (start),
    .length  (length),
    .rd_data (rd_data),
    .rd_addr (rd_addr),
    .led     (led),
    .busy    (busy),
    .done    (done)
  );

  assign rd_data = rom[rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge: issues start and pushes the first npush colours plus optional done.
  task automatic issue(input int len, input int npush, input bit want_done);
    int l;
    ev_t e;
    start  = 1'b1;
    length = len[3:0];
    t0     = cyc;
    l      = (len > N) ? N : len;
    for (int i = 0; i < l && i < npush; i++) begin
      e.led  = 1 << rom[i];
      e.cyc  = t0 + 2 + i * (1 + ON + OFF);
      e.addr = i;
      led_q.push_back(e);
    end
    if (want_done) done_q.push_back((l == 0) ? t0 + 1 : t0 + l * (1 + ON + OFF) - OFF + 1);
    @(negedge clk);
    start  = 1'b0;
    length = 4'd0;
  endtask

  task automatic wait_until(input int target);
    for (int k = 0; k < 300 && cyc != target; k++) @(negedge clk);
    check("wait_target", cyc, target);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && (led_q.size() != 0 || done_q.size() != 0); k++) @(negedge clk);
    check("drain_led_q", led_q.size(), 0);
    check("drain_done_q", done_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: compares each LED rise, its lit duration, and every done pulse.
  initial begin
    logic [3:0] prev_led;
    bit         lit;
    int         rise;
    ev_t        e;
    int         exp_done;
    prev_led = 4'd0;
    lit      = 1'b0;
    rise     = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_led = 4'd0;
        lit      = 1'b0;
      end else begin
        check("rd_addr_in_range", int'(rd_addr <= 4'd9), 1);
        if (led != 4'd0 && prev_led == 4'd0) begin
          if (led_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_led actual=%b required=none (cycle %0d)", led, cyc);
          end else begin
            e = led_q.pop_front();
            check("led_value", int'(led), e.led);
            check("led_cycle", cyc, e.cyc);
            check("led_addr", int'(rd_addr), e.addr);
            check("busy_lit", int'(busy), 1);
          end
          lit  = 1'b1;
          rise = cyc;
        end else if (led == 4'd0 && prev_led != 4'd0 && lit) begin
          check("on_length", cyc - rise, ON);
          lit = 1'b0;
        end
        if (done) begin
          if (done_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
          end else begin
            exp_done = done_q.pop_front();
            check("done_cycle", cyc, exp_done);
            check("busy_at_done", int'(busy), 0);
          end
        end
        prev_led = led;
      end
    end
  end

  initial begin
    int tb2;
    total  = 0;
    bad    = 0;
    cyc    = 0;
    reset  = 1'b0;
    start  = 1'b0;
    length = 4'd0;
`ifdef SEQUENCE_PLAYER_ABORT_EN
    abort  = 1'b0;
`endif
    rom = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1,
            2'd3, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_led", int'(led), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_rd_addr", int'(rd_addr), 0);
    check("reset_done", int'(done), 0);

    // Three colours: 0100 @2, 0001 @9, 1000 @16, done @20.
    issue(3, 3, 1'b1);
    drain();
    issue(1, 1, 1'b1);
    drain();
    issue(0, 0, 1'b1);
    drain();
    // Clamped length: ten colours, done at cycle 69.
    issue(15, 15, 1'b1);
    drain();

    // Second start during playback must be ignored.
    issue(2, 2, 1'b1);
    wait_until(t0 + 5);
    start  = 1'b1;
    length = 4'd3;
    @(negedge clk);
    start  = 1'b0;
    length = 4'd0;
    drain();

    // Back-to-back: restart sampled in the done cycle.
    issue(1, 1, 1'b1);
    wait_until(t0 + 6);
    issue(2, 2, 1'b1);
    drain();

    // Asynchronous reset while the first colour is lit.
    issue(3, 1, 1'b0);
    wait_until(t0 + 3);
    check("pre_reset_led", int'(led), 4);
    #2 reset = 1'b0;
    #1;
    check("async_reset_led", int'(led), 0);
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_rd_addr", int'(rd_addr), 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    repeat (30) @(negedge clk);
    drain();

`ifdef SEQUENCE_PLAYER_ABORT_EN
    // Abort in the gap after the first colour; nothing further, then a clean replay.
    issue(3, 1, 1'b0);
    tb2 = t0;
    wait_until(tb2 + 6);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_led", int'(led), 0);
    repeat (25) @(negedge clk);
    issue(2, 2, 1'b1);
    drain();
`else
    tb2 = 0;
`endif

    check("final_led_q", led_q.size(), 0);
    check("final_done_q", done_q.size(), tb2 * 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
